// File: rtl/i2s_capture_if.sv
// Bundles the microphone serial lines and the PCM valid/ready stream of i2s_capture.
// master is the capture block; slave is the microphone / sample-FIFO side.
interface i2s_capture_if #(
    parameter int OUT_WIDTH = 16
);
    logic                 i2s_clk;
    logic                 i2s_ws;
    logic                 i2s_sd;
    logic [OUT_WIDTH-1:0] pcm_data;
    logic                 pcm_valid;
    logic                 pcm_ready;

    modport master (
        output i2s_clk,
        output i2s_ws,
        input  i2s_sd,
        output pcm_data,
        output pcm_valid,
        input  pcm_ready
    );

    modport slave (
        input  i2s_clk,
        input  i2s_ws,
        output i2s_sd,
        input  pcm_data,
        input  pcm_valid,
        output pcm_ready
    );
endinterface

// File: rtl/i2s_capture.sv
// Master-mode I2S receiver: generates bit clock / word select, deserialises one channel,
// decimates, truncates to the MSBs and offers samples on a one-deep valid/ready stage.
module i2s_capture #(
    parameter int SCK_HALF_DIV  = 8,
    parameter int DATA_SIZE     = 24,
    parameter int OUT_WIDTH     = 16,
    parameter int REDUCE_FACTOR = 2,
    parameter int CHANNEL       = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    i2s_capture_if.master        bus,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    localparam int   DIV_W    = (SCK_HALF_DIV > 2) ? $clog2(SCK_HALF_DIV) : 1;
    localparam int   DEC_W    = (REDUCE_FACTOR > 1) ? $clog2(REDUCE_FACTOR) : 1;
    localparam logic CHAN_BIT = (CHANNEL != 0) ? 1'b1 : 1'b0;

    logic [DIV_W-1:0]     div_cnt_r;
    logic                 sck_r;
    logic [5:0]           bit_cnt_r;
    logic                 ws_r;
    logic [DATA_SIZE-1:0] shift_r;
    logic                 word_done_r;
    logic [DEC_W-1:0]     decim_cnt_r;
    logic [OUT_WIDTH-1:0] pcm_data_r;
    logic                 pcm_valid_r;

    logic                 div_wrap_s;
    logic                 rise_s;
    logic                 fall_s;
    logic [4:0]           slot_s;
    logic                 in_chan_s;
    logic                 capture_s;
    logic                 complete_s;
    logic                 emit_s;
    logic                 accept_s;
    logic [5:0]           bit_inc_s;
    logic [DEC_W-1:0]     decim_next_s;
    logic [OUT_WIDTH-1:0] word_s;

    // Bit-clock edge strobes, slot decode and handshake qualifiers.
    always_comb begin
        div_wrap_s   = (div_cnt_r == DIV_W'(SCK_HALF_DIV - 1));
        rise_s       = en && div_wrap_s && !sck_r;
        fall_s       = en && div_wrap_s && sck_r;
        slot_s       = bit_cnt_r[4:0];
        in_chan_s    = (bit_cnt_r[5] == CHAN_BIT);
        // Slot 0 carries the one-bit I2S delay; the MSB arrives at slot 1.
        capture_s    = rise_s && in_chan_s && (slot_s >= 5'd1) && (slot_s <= 5'(DATA_SIZE));
        complete_s   = rise_s && in_chan_s && (slot_s == 5'(DATA_SIZE));
        emit_s       = word_done_r && (decim_cnt_r == {DEC_W{1'b0}});
        accept_s     = pcm_valid_r && bus.pcm_ready;
        bit_inc_s    = bit_cnt_r + 6'd1;
        word_s       = shift_r[DATA_SIZE-1 -: OUT_WIDTH];
        decim_next_s = decim_cnt_r;
        if (decim_cnt_r == DEC_W'(REDUCE_FACTOR - 1)) begin
            decim_next_s = {DEC_W{1'b0}};
        end else begin
            decim_next_s = decim_cnt_r + DEC_W'(1);
        end
    end

    // Half-period divider and bit clock; disable parks the clock low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sck_r     <= 1'b0;
        end else if (!en) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sck_r     <= 1'b0;
        end else if (div_wrap_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sck_r     <= ~sck_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
            sck_r     <= sck_r;
        end
    end

    // Frame position; word select tracks the frame half and moves only on falling edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 6'd0;
            ws_r      <= 1'b0;
        end else if (!en) begin
            bit_cnt_r <= 6'd0;
            ws_r      <= 1'b0;
        end else if (fall_s) begin
            bit_cnt_r <= bit_inc_s;
            ws_r      <= bit_inc_s[5];
        end else begin
            bit_cnt_r <= bit_cnt_r;
            ws_r      <= ws_r;
        end
    end

    // Deserialiser, MSB first; a disable throws away any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {DATA_SIZE{1'b0}};
        end else if (!en) begin
            shift_r <= {DATA_SIZE{1'b0}};
        end else if (capture_s) begin
            shift_r <= DATA_SIZE'({shift_r, bus.i2s_sd});
        end else begin
            shift_r <= shift_r;
        end
    end

    // One-cycle marker that the selected slot has just been fully shifted in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_done_r <= 1'b0;
        end else begin
            word_done_r <= complete_s;
        end
    end

    // Decimation phase; zero means the next completed word is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_cnt_r <= {DEC_W{1'b0}};
        end else if (!en) begin
            decim_cnt_r <= {DEC_W{1'b0}};
        end else if (word_done_r) begin
            decim_cnt_r <= decim_next_s;
        end else begin
            decim_cnt_r <= decim_cnt_r;
        end
    end

    // One-deep output stage: a new word may replace the held one only when it leaves this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_data_r  <= {OUT_WIDTH{1'b0}};
            pcm_valid_r <= 1'b0;
        end else if (emit_s && (!pcm_valid_r || accept_s)) begin
            pcm_data_r  <= word_s;
            pcm_valid_r <= 1'b1;
        end else if (accept_s) begin
            pcm_data_r  <= pcm_data_r;
            pcm_valid_r <= 1'b0;
        end else begin
            pcm_data_r  <= pcm_data_r;
            pcm_valid_r <= pcm_valid_r;
        end
    end

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (emit_s && pcm_valid_r && !accept_s) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun;
        end
    end

    assign bus.i2s_clk   = sck_r;
    assign bus.i2s_ws    = ws_r;
    assign bus.pcm_data  = pcm_data_r;
    assign bus.pcm_valid = pcm_valid_r;

endmodule

// File: tb/tb_i2s_capture.sv
// Randomised bench for i2s_capture: two instances (left/decimate-by-2, right/no decimation)
// share one microphone model and are compared every cycle against a frame-arithmetic reference.
module tb_i2s_capture;

    localparam int H  = 2;
    localparam int DS = 24;
    localparam int OW = 16;
    localparam int FR = 128 * H;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic clr0, clr1;
    logic ov0, ov1;

    i2s_capture_if #(.OUT_WIDTH(OW)) bus0 ();
    i2s_capture_if #(.OUT_WIDTH(OW)) bus1 ();

    i2s_capture #(.SCK_HALF_DIV(H), .DATA_SIZE(DS), .OUT_WIDTH(OW), .REDUCE_FACTOR(2), .CHANNEL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus0.master), .overrun(ov0), .clr_overrun(clr0));
    i2s_capture #(.SCK_HALF_DIV(H), .DATA_SIZE(DS), .OUT_WIDTH(OW), .REDUCE_FACTOR(1), .CHANNEL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus1.master), .overrun(ov1), .clr_overrun(clr1));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int           n;
    logic [23:0]  cur_word [2];
    logic [23:0]  lq[$];
    logic [23:0]  rq[$];
    bit           mv   [2];
    logic [15:0]  md   [2];
    bit           mo   [2];
    int           dc   [2];
    bit           pend [2];
    logic [23:0]  pw   [2];
    int           rf   [2] = '{2, 1};
    int           chn  [2] = '{0, 1};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        n = 0;
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; md[d] = 16'h0000; mo[d] = 1'b0; dc[d] = 0; pend[d] = 1'b0;
        end
    endtask

    // Microphone: puts the bit for the coming clk edge on sd; random filler outside the word bits.
    task automatic drive_next();
        int nn, b, s, c;
        logic sd_v;
        nn   = (en && rst_n) ? n + 1 : 0;
        sd_v = 1'($urandom_range(0, 1));
        if (en && rst_n && (nn % (2 * H)) == H) begin
            b = (nn / (2 * H)) % 64;
            s = b % 32;
            c = b / 32;
            if (s == 1) begin
                if (c == 0) cur_word[0] = (lq.size() > 0) ? lq.pop_front() : 24'($urandom);
                else        cur_word[1] = (rq.size() > 0) ? rq.pop_front() : 24'($urandom);
            end
            if (s >= 1 && s <= DS) sd_v = cur_word[c][DS - s];
        end
        bus0.i2s_sd = sd_v;
        bus1.i2s_sd = sd_v;
    endtask

    task automatic model_update();
        bit rdy, clr, acc, emit, was_v;
        int b, s, c;
        if (!rst_n) begin
            reset_model();
        end else begin
            for (int d = 0; d < 2; d++) begin
                rdy   = (d == 0) ? bus0.pcm_ready : bus1.pcm_ready;
                clr   = (d == 0) ? clr0 : clr1;
                was_v = mv[d];
                acc   = was_v && rdy;
                emit  = pend[d] && (dc[d] == 0);
                if (!en)          dc[d] = 0;
                else if (pend[d]) dc[d] = (dc[d] + 1) % rf[d];
                if (emit && was_v && !acc) mo[d] = 1'b1;
                else if (clr)              mo[d] = 1'b0;
                if (emit && (!was_v || acc)) begin
                    md[d] = pw[d][DS-1 -: OW];
                    mv[d] = 1'b1;
                end else if (acc) begin
                    mv[d] = 1'b0;
                end
                pend[d] = 1'b0;
            end
            n = en ? n + 1 : 0;
            if (en && (n % (2 * H)) == H) begin
                b = (n / (2 * H)) % 64;
                s = b % 32;
                c = b / 32;
                for (int d = 0; d < 2; d++) begin
                    if (s == DS && c == chn[d]) begin
                        pend[d] = 1'b1;
                        pw[d]   = cur_word[c];
                    end
                end
            end
        end
    endtask

    task automatic compare();
        logic exp_sck, exp_ws;
        exp_sck = 1'((n / H) % 2);
        exp_ws  = 1'(((n / (2 * H)) % 64) / 32);
        check_val("sck0",   bus0.i2s_clk,   exp_sck);
        check_val("ws0",    bus0.i2s_ws,    exp_ws);
        check_val("sck1",   bus1.i2s_clk,   exp_sck);
        check_val("ws1",    bus1.i2s_ws,    exp_ws);
        check_val("valid0", bus0.pcm_valid, mv[0]);
        check_val("data0",  bus0.pcm_data,  md[0]);
        check_val("ovr0",   ov0,            mo[0]);
        check_val("valid1", bus1.pcm_valid, mv[1]);
        check_val("data1",  bus1.pcm_data,  md[1]);
        check_val("ovr1",   ov1,            mo[1]);
    endtask

    task automatic step();
        drive_next();
        @(posedge clk);
        #1;
        model_update();
        compare();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_sck0"},   bus0.i2s_clk,   32'd0);
        check_val({tag, "_ws0"},    bus0.i2s_ws,    32'd0);
        check_val({tag, "_data0"},  bus0.pcm_data,  32'd0);
        check_val({tag, "_valid0"}, bus0.pcm_valid, 32'd0);
        check_val({tag, "_ovr0"},   ov0,            32'd0);
        check_val({tag, "_data1"},  bus1.pcm_data,  32'd0);
        check_val({tag, "_valid1"}, bus1.pcm_valid, 32'd0);
        check_val({tag, "_ovr1"},   ov1,            32'd0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; en = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        bus0.pcm_ready = 1'b1; bus1.pcm_ready = 1'b1;
        bus0.i2s_sd = 1'b0; bus1.i2s_sd = 1'b0;
        cur_word[0] = 24'h000000; cur_word[1] = 24'h000000;
        reset_model();
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) step();

        // Fixed left/right words, always ready.
        repeat (4) begin lq.push_back(24'hABCDEF); rq.push_back(24'h123456); end
        en = 1'b1;
        repeat (4 * FR) step();
        check_val("t1_data0", bus0.pcm_data, 32'h0000ABCD);
        check_val("t1_data1", bus1.pcm_data, 32'h00001234);

        // Decimation by two from a fresh enable.
        en = 1'b0;
        repeat (4) step();
        lq.push_back(24'h010000); lq.push_back(24'h020000);
        lq.push_back(24'h030000); lq.push_back(24'h040000);
        en = 1'b1;
        repeat (4 * FR) step();
        check_val("t3_data0", bus0.pcm_data, 32'h00000300);

        // Random words, random backpressure and overrun clears.
        repeat (8 * FR) begin
            bus0.pcm_ready = ($urandom_range(0, 3) != 0);
            bus1.pcm_ready = ($urandom_range(0, 3) != 0);
            clr0 = ($urandom_range(0, 49) == 0);
            clr1 = ($urandom_range(0, 49) == 0);
            step();
        end
        bus0.pcm_ready = 1'b1; bus1.pcm_ready = 1'b1;
        clr0 = 1'b1; clr1 = 1'b1;
        step();
        clr0 = 1'b0; clr1 = 1'b0;
        repeat (8) step();

        // Backpressure on the right-channel instance: second word is dropped.
        en = 1'b0;
        repeat (4) step();
        rq.push_back(24'h111111); rq.push_back(24'h222222);
        bus1.pcm_ready = 1'b0;
        en = 1'b1;
        repeat (2 * FR) step();
        check_val("t4_data1",  bus1.pcm_data,  32'h00001111);
        check_val("t4_valid1", bus1.pcm_valid, 32'd1);
        check_val("t4_ovr1",   ov1,            32'd1);
        bus1.pcm_ready = 1'b1;
        step();
        check_val("t4_drop1", bus1.pcm_valid, 32'd0);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        check_val("t4_clr1", ov1, 32'd0);

        // Disable at bit 10 of the left slot, then restart.
        guard = 0;
        while (!(((n / (2 * H)) % 64) == 10) && guard < 2 * FR) begin
            step();
            guard++;
        end
        check_val("t5_reach", (guard < 2 * FR) ? 32'd1 : 32'd0, 32'd1);
        en = 1'b0;
        step();
        check_val("t5_sck0", bus0.i2s_clk, 32'd0);
        check_val("t5_ws0",  bus0.i2s_ws,  32'd0);
        repeat (10) step();
        en = 1'b1;
        repeat (3 * FR) step();

        // Asynchronous reset mid-word with a sample pending.
        bus0.pcm_ready = 1'b0;
        repeat (FR + FR / 4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        repeat (3) step();
        rst_n = 1'b1;
        bus0.pcm_ready = 1'b1;
        repeat (3 * FR) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_capture.md
Name: i2s_capture

Overview:
- Master-mode I2S receiver for the MEMS microphone, one stage upstream of the sample FIFO / SPI readout.
- Generates the mic bit clock and word select, and deserialises the selected channel's DATA_SIZE-bit word.
- Decimates by REDUCE_FACTOR, truncates to OUT_WIDTH MSBs, and presents samples on a valid/ready interface feeding the FIFO write side.

Parameters:
- SCK_HALF_DIV, 8, system clocks per half bit-clock period (i2s_clk = clk/(2*SCK_HALF_DIV)); legal range >= 2.
- DATA_SIZE, 24, significant bits per I2S slot; legal range 1..31.
- OUT_WIDTH, 16, width of pcm_data; legal range 1..DATA_SIZE.
- REDUCE_FACTOR, 2, emit 1 of every N captured words; legal range >= 1.
- CHANNEL, 0, slot captured: 0 = left (ws=0), 1 = right (ws=1).

Ports:
- clk, in, 1, system clock (25 MHz).
- rst_n, in, 1, reset, asynchronous, active-low.
- en, in, 1, capture enable.
- i2s_clk, out, 1, bit clock to mic.
- i2s_ws, out, 1, word select to mic.
- i2s_sd, in, 1, serial data from mic.
- pcm_data, out, OUT_WIDTH, signed sample, MSB-aligned truncation.
- pcm_valid, out, 1, sample available.
- pcm_ready, in, 1, downstream accepts sample.
- overrun, out, 1, sticky: a sample was dropped.
- clr_overrun, in, 1, synchronous clear of overrun.

Behaviour:
- Reset (rst_n low, async): i2s_clk=0, i2s_ws=0, pcm_data=0, pcm_valid=0, overrun=0; div/bit/decim counters and shift register cleared.
- Clock generation: div_cnt counts 0..SCK_HALF_DIV-1. At wrap, i2s_clk toggles.
  - "Rise event" = the clk edge where i2s_clk goes 0->1.
  - "Fall event" = the clk edge where i2s_clk goes 1->0.
- Frame: 64 bit clocks. bit_cnt (6 bits) increments on each fall event, wrapping 63->0. i2s_ws = bit_cnt[5], registered, so ws changes only at fall events.
- Slot position s = bit_cnt[4:0]. MSB is at s=1 (standard I2S one-bit delay).
  - On a rise event with s in 1..DATA_SIZE and bit_cnt[5]==CHANNEL: shift i2s_sd (sampled at that clk edge) into the LSB of the shift register.
  - Other slot positions are ignored.
- Word complete: rise event at s==DATA_SIZE in the selected channel. On the next clk, decim_cnt is evaluated.
  - If decim_cnt==0, the word is emitted; decim_cnt then increments, wrapping at REDUCE_FACTOR-1.
  - The first word after enable/reset is always emitted.
- Emit: pcm_data <= word[DATA_SIZE-1 -: OUT_WIDTH]; pcm_valid <= 1.
  - Latency is 1 clk from the completing rise event.
- Handshake: pcm_valid stays high and pcm_data stays stable until a clk with pcm_valid && pcm_ready. pcm_valid drops the next cycle unless a new emit occurs in the same cycle.
  - Emit while valid is pending and not accepted that cycle: new word dropped, pcm_data unchanged, overrun <= 1.
  - Emit in the same cycle as acceptance: new word loaded, pcm_valid stays 1, no overrun.
- overrun: cleared only by reset or clr_overrun. If clr_overrun and a new overrun coincide, overrun ends at 1.
- en low: synchronously, the next clk forces i2s_clk=0, i2s_ws=0, and clears div_cnt, bit_cnt, decim_cnt and the shift register.
  - Partial words are discarded.
  - A pending pcm_valid/pcm_data is retained until accepted.
- en rising: the first rise event occurs SCK_HALF_DIV clks later with bit_cnt=0.
- Reset mid-word: everything is cleared immediately. No partial sample is ever emitted.

Test Plan:
1. SCK_HALF_DIV=2, pcm_ready=1, mic model drives left=24'hABCDEF, right=24'h123456 -> i2s_clk period 4 clk, ws toggles every 32 bit clocks; pcm_data=16'hABCD with pcm_valid for 1 clk, 1 clk after rise event s=24; nothing emitted for right.
2. CHANNEL=1, same stimulus -> pcm_data=16'h1234 only.
3. REDUCE_FACTOR=2, left values 24'h010000, 24'h020000, 24'h030000, 24'h040000 over 4 frames -> exactly 2 emits: 16'h0100, 16'h0300.
4. REDUCE_FACTOR=1, pcm_ready=0 for 2 frames, left=24'h111111 then 24'h222222 -> pcm_data holds 16'h1111, overrun=1; raise ready -> one accept, valid drops; clr_overrun -> overrun=0.
5. Deassert en at bit_cnt=10 of the left slot -> i2s_clk=0 and ws=0 the next clk, no emit; reassert -> next emit is a full fresh word with the correct value.
6. Pulse rst_n low mid-word and during pending valid -> all outputs 0 asynchronously; after release, first complete frame is emitted correctly.
